// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//   Program loader / write sequencer for the 16-bit instruction memory.
//   A valid/ready stream of instruction words is written to consecutive
//   word addresses starting at a programmable base. The processor is held in
//   stall while a load is in progress and released once the word flagged
//   with in_last has been written. A word count and a running 16-bit
//   checksum are kept so software can verify the image.
//
// Parameters
//   ADDR_W     instruction-memory word-address width (1..31)
//   MAX_WORDS  maximum words accepted per load (<= 2**ADDR_W)
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   load_start   1-cycle pulse starting a load (honoured in IDLE/DONE/ERROR)
//   base_addr    first write address, captured with an accepted load_start
//   in_valid     stream word valid
//   in_data      stream instruction word
//   in_last      marks the final word of the program
//   in_ready     loader accepts a word this cycle (high only while loading)
//   mem_wr_addr  instruction-memory write address (zero above ADDR_W)
//   mem_wr_data  instruction-memory write data
//   mem_wr_en    instruction-memory write enable
//   cpu_stall    1 = processor fetch frozen
//   load_done    level: last load completed successfully
//   load_error   level: last load overflowed MAX_WORDS
//   word_count   words written in the current or last load
//   checksum     sum mod 2**16 of the words written in the current or last load
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int ADDR_W    = 20,
    parameter int MAX_WORDS = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [31:0]       base_addr,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [31:0]       mem_wr_addr,
    output logic [15:0]       mem_wr_data,
    output logic              mem_wr_en,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Word count at which a further beat is an overflow.
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

    // Running checksum accumulate, wraps mod 2**16.
    function automatic logic [15:0] csum_add(input logic [15:0] sum,
                                             input logic [15:0] word);
        return sum + word;
    endfunction

    // Zero-extend a word pointer onto the 32-bit memory address bus.
    function automatic logic [31:0] addr_ext(input logic [ADDR_W-1:0] ptr);
        logic [31:0] r;
        r             = 32'd0;
        r[ADDR_W-1:0] = ptr;
        return r;
    endfunction

    state_t              state_q,       state_d;
    logic [ADDR_W-1:0]   ptr_q,         ptr_d;
    logic                mem_wr_en_q,   mem_wr_en_d;
    logic [31:0]         mem_wr_addr_q, mem_wr_addr_d;
    logic [15:0]         mem_wr_data_q, mem_wr_data_d;
    logic                cpu_stall_q,   cpu_stall_d;
    logic                load_done_q,   load_done_d;
    logic                load_error_q,  load_error_d;
    logic [ADDR_W:0]     word_count_q,  word_count_d;
    logic [15:0]         checksum_q,    checksum_d;

    logic                beat_s;
    logic                base_addr_unused_s;

    // Address bits above the memory width carry no meaning for the loader.
    assign base_addr_unused_s = ^base_addr[31:ADDR_W];

    // A beat is only possible while loading; in_ready is decoded from state.
    assign in_ready = (state_q == ST_LOAD);
    assign beat_s   = in_valid & in_ready;

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        mem_wr_en_d   = 1'b0;
        mem_wr_addr_d = mem_wr_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        cpu_stall_d   = cpu_stall_q;
        load_done_d   = load_done_q;
        load_error_d  = load_error_q;
        word_count_d  = word_count_q;
        checksum_d    = checksum_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    // Stall reasserts on the same edge that leaves DONE.
                    state_d      = ST_LOAD;
                    ptr_d        = base_addr[ADDR_W-1:0];
                    word_count_d = '0;
                    checksum_d   = 16'h0000;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    cpu_stall_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (beat_s) begin
                    if (word_count_q == MAX_CNT) begin
                        // Overflow word is dropped: not written, not counted.
                        state_d      = ST_ERROR;
                        load_error_d = 1'b1;
                        cpu_stall_d  = 1'b1;
                    end else begin
                        mem_wr_en_d   = 1'b1;
                        mem_wr_addr_d = addr_ext(ptr_q);
                        mem_wr_data_d = in_data;
                        // Pointer wraps naturally at the top of memory.
                        ptr_d         = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        word_count_d  = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
                        checksum_d    = csum_add(checksum_q, in_data);
                        if (in_last) begin
                            state_d     = ST_DONE;
                            load_done_d = 1'b1;
                            cpu_stall_d = 1'b0;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cpu_stall_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= 32'h0000_0000;
            mem_wr_data_q <= 16'h0000;
            cpu_stall_q   <= 1'b1;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            word_count_q  <= '0;
            checksum_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            cpu_stall_q   <= cpu_stall_d;
            load_done_q   <= load_done_d;
            load_error_q  <= load_error_d;
            word_count_q  <= word_count_d;
            checksum_q    <= checksum_d;
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign cpu_stall   = cpu_stall_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign word_count  = word_count_q;
    assign checksum    = checksum_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

    localparam int ADDR_W    = 20;
    localparam int MAX_WORDS = 4;

    logic              clk;
    logic              reset;
    logic              load_start;
    logic [31:0]       base_addr;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic [31:0]       mem_wr_addr;
    logic [15:0]       mem_wr_data;
    logic              mem_wr_en;
    logic              cpu_stall;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   word_count;
    logic [15:0]       checksum;

    int checks = 0;
    int errors = 0;

    inst_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en),
        .cpu_stall   (cpu_stall),
        .load_done   (load_done),
        .load_error  (load_error),
        .word_count  (word_count),
        .checksum    (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Start a load at the given base (one-cycle load_start pulse).
    task automatic start_load(input logic [31:0] base);
        load_start = 1'b1;
        base_addr  = base;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (cpu_stall !== 1'b1 || mem_wr_en !== 1'b0 || in_ready !== 1'b0 ||
            word_count !== 21'd0 || checksum !== 16'h0000 || load_done !== 1'b0 ||
            load_error !== 1'b0 || mem_wr_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: stall=%b en=%b rdy=%b cnt=%0d sum=%h done=%b err=%b addr=%h, expected 1 0 0 0 0000 0 0 0",
                     cpu_stall, mem_wr_en, in_ready, word_count, checksum, load_done, load_error, mem_wr_addr);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [3];
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
        start_load(32'h0000_0010);
        checks++;
        if (in_ready !== 1'b1 || cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_enter_load: rdy=%b stall=%b, expected 1 1", in_ready, cpu_stall);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = w[k];
            in_last = (k == 2);
            cyc();
            checks++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h10 + 32'(k) || mem_wr_data !== w[k]) begin
                errors++;
                $display("FAIL b2b_write%0d: en=%b addr=%h data=%h, expected 1 %h %h",
                         k, mem_wr_en, mem_wr_addr, mem_wr_data, 32'h10 + 32'(k), w[k]);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (word_count !== 21'd3 || checksum !== 16'h6666 || cpu_stall !== 1'b0 ||
            load_done !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: cnt=%0d sum=%h stall=%b done=%b rdy=%b, expected 3 6666 0 1 0",
                     word_count, checksum, cpu_stall, load_done, in_ready);
        end
        // Stream input is ignored in DONE.
        in_valid = 1'b1;
        in_data  = 16'h7777;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || word_count !== 21'd3 || checksum !== 16'h6666) begin
            errors++;
            $display("FAIL done_ignores_stream: en=%b cnt=%0d sum=%h, expected 0 3 6666",
                     mem_wr_en, word_count, checksum);
        end
    endtask

    task automatic test_wrap_gaps();
        start_load(32'h000F_FFFF);
        checks++;
        if (cpu_stall !== 1'b1 || load_done !== 1'b0 || word_count !== 21'd0 || checksum !== 16'h0000) begin
            errors++;
            $display("FAIL restart_from_done: stall=%b done=%b cnt=%0d sum=%h, expected 1 0 0 0000",
                     cpu_stall, load_done, word_count, checksum);
        end
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h000F_FFFF || mem_wr_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL wrap_write0: en=%b addr=%h data=%h, expected 1 000fffff aaaa",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        for (int g = 0; g < 2; g++) begin
            cyc();
            checks++;
            if (mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL gap%0d_no_write: en=%b, expected 0", g, mem_wr_en);
            end
        end
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_last  = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h0000_0000 || mem_wr_data !== 16'h5555 ||
            word_count !== 21'd2 || checksum !== 16'hFFFF || load_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_write1: en=%b addr=%h data=%h cnt=%0d sum=%h done=%b, expected 1 00000000 5555 2 ffff 1",
                     mem_wr_en, mem_wr_addr, mem_wr_data, word_count, checksum, load_done);
        end
    endtask

    task automatic test_overflow();
        start_load(32'h0000_0100);
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (k < 4) begin
                checks++;
                if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h100 + 32'(k) || mem_wr_data !== 16'(k + 1)) begin
                    errors++;
                    $display("FAIL ovf_write%0d: en=%b addr=%h data=%h, expected 1 %h %h",
                             k, mem_wr_en, mem_wr_addr, mem_wr_data, 32'h100 + 32'(k), 16'(k + 1));
                end
                in_data = 16'(k + 2);
            end else begin
                checks++;
                if (mem_wr_en !== 1'b0 || load_error !== 1'b1 || word_count !== 21'd4 ||
                    checksum !== 16'h000A || cpu_stall !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_error: en=%b err=%b cnt=%0d sum=%h stall=%b rdy=%b done=%b, expected 0 1 4 000a 1 0 0",
                             mem_wr_en, load_error, word_count, checksum, cpu_stall, in_ready, load_done);
                end
            end
        end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || load_error !== 1'b1 || word_count !== 21'd4) begin
            errors++;
            $display("FAIL ovf_hold: en=%b err=%b cnt=%0d, expected 0 1 4", mem_wr_en, load_error, word_count);
        end
    endtask

    task automatic test_reset_mid_load();
        start_load(32'h0000_0200);
        checks++;
        if (load_error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL exit_error: err=%b rdy=%b, expected 0 1", load_error, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 16'h0A0A;
        cyc();
        in_data  = 16'h0B0B;
        cyc();
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h201 || mem_wr_data !== 16'h0B0B) begin
            errors++;
            $display("FAIL rst_mid_write1: en=%b addr=%h data=%h, expected 1 00000201 0b0b",
                     mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        in_data = 16'h0C0C;
        reset   = 1'b1;
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || in_ready !== 1'b0 || cpu_stall !== 1'b1 || word_count !== 21'd0) begin
            errors++;
            $display("FAIL rst_mid_idle: en=%b rdy=%b stall=%b cnt=%0d, expected 0 0 1 0",
                     mem_wr_en, in_ready, cpu_stall, word_count);
        end
        cyc();
        checks++;
        if (mem_wr_en !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_write: en=%b rdy=%b, expected 0 0", mem_wr_en, in_ready);
        end
        start_load(32'h0000_0300);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_last  = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h300 || mem_wr_data !== 16'hBEEF ||
            word_count !== 21'd1 || checksum !== 16'hBEEF || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reload_after_rst: en=%b addr=%h data=%h cnt=%0d sum=%h stall=%b, expected 1 00000300 beef 1 beef 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, word_count, checksum, cpu_stall);
        end
    endtask

    task automatic test_start_ignored();
        start_load(32'h0000_0040);
        checks++;
        if (cpu_stall !== 1'b1 || load_done !== 1'b0 || word_count !== 21'd0 || checksum !== 16'h0000) begin
            errors++;
            $display("FAIL done_restart_clear: stall=%b done=%b cnt=%0d sum=%h, expected 1 0 0 0000",
                     cpu_stall, load_done, word_count, checksum);
        end
        in_valid = 1'b1;
        in_data  = 16'h0001;
        cyc();
        in_valid   = 1'b0;
        load_start = 1'b1;
        base_addr  = 32'h0000_0999;
        cyc();
        load_start = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b0 || word_count !== 21'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_ignored: en=%b cnt=%0d rdy=%b, expected 0 1 1",
                     mem_wr_en, word_count, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 16'h0002;
        in_last  = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== 32'h41 || mem_wr_data !== 16'h0002 ||
            word_count !== 21'd2 || checksum !== 16'h0003 || load_done !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_continue: en=%b addr=%h data=%h cnt=%0d sum=%h done=%b, expected 1 00000041 0002 2 0003 1",
                     mem_wr_en, mem_wr_addr, mem_wr_data, word_count, checksum, load_done);
        end
    endtask

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        base_addr  = 32'h0;
        in_valid   = 1'b0;
        in_data    = 16'h0;
        in_last    = 1'b0;
        #2;
        test_reset();
        test_back_to_back();
        test_wrap_gaps();
        test_overflow();
        test_reset_mid_load();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
